// File: rtl/rca_arith_pkg.sv
// Shared types for the sequential arithmetic library (divider side).
package rca_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the per-bit step counter for a given operand width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rca_div_step.sv
// One restoring-division step: shift in the next dividend bit, then try
// subtracting the divisor with a ripple-carry adder (inverted D, carry-in 1).
// The remainder is held to W+1 bits by the caller; the subtract runs one bit
// wider so its carry-out is a clean "no borrow" indication.
import rca_arith_pkg::*;

module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r_i,
    input  logic         bit_i,
    input  logic [W-1:0] d_i,
    output logic [W:0]   r_o,
    output logic         q_o
);

    logic [W+1:0] r_sh;
    logic [W+1:0] d_inv;
    logic [W+1:0] diff;
    logic [W+2:0] carry;

    assign r_sh  = {r_i, bit_i};
    assign d_inv = ~{2'b00, d_i};

    // Ripple-carry subtract r_sh - d, bit by bit.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= W + 1; i++) begin
            diff[i]      = r_sh[i] ^ d_inv[i] ^ carry[i];
            carry[i + 1] = (r_sh[i] & d_inv[i]) | (carry[i] & (r_sh[i] ^ d_inv[i]));
        end
    end

    // Carry-out set means no borrow: keep the difference, quotient bit is 1.
    assign q_o = carry[W+2];
    assign r_o = q_o ? diff[W:0] : r_sh[W:0];

endmodule

// File: rtl/rca_div.sv
// Sequential radix-2 restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, start/done handshake, registered results.
//
// state | meaning
// IDLE  | waiting for start; previous results held
// RUN   | shifting out one quotient bit per cycle
// DONE  | results valid, done pulse high for this single cycle
import rca_arith_pkg::*;

module rca_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   in_div_a,
    input  logic [DATA_WIDTH-1:0]     in_div_b,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     out_div_quot,
    output logic [DATA_WIDTH-1:0]     out_div_rem,
    output logic                      out_div_ovf
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    r_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  d_q;
    logic [W-1:0]  quot_q;
    logic [W-1:0]  rem_q;
    logic          ovf_q;
    logic          done_q;
    logic          busy_q;

    logic [W:0]    r_d;
    logic          qbit_d;
    logic [W-1:0]  q_d;

    div_step #(.W(W)) u_step (
        .r_i   (r_q),
        .bit_i (q_q[W-1]),
        .d_i   (d_q),
        .r_o   (r_d),
        .q_o   (qbit_d)
    );

    assign q_d = {q_q[W-2:0], qbit_d};

    // Control FSM with datapath and registered outputs; enable low clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q <= in_div_b;
                        // A high half >= D would need more than W quotient bits;
                        // D == 0 falls into the same comparison.
                        if ((in_div_b == '0) || (in_div_a[2*W-1:W] >= in_div_b)) begin
                            state_q <= ST_DONE;
                            quot_q  <= '1;
                            rem_q   <= '0;
                            ovf_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            r_q     <= {1'b0, in_div_a[2*W-1:W]};
                            q_q     <= in_div_a[W-1:0];
                            cnt_q   <= CW'(W - 1);
                            quot_q  <= '0;
                            rem_q   <= '0;
                            ovf_q   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        quot_q  <= q_d;
                        rem_q   <= r_d[W-1:0];
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign out_div_quot = quot_q;
    assign out_div_rem  = rem_q;
    assign out_div_ovf  = ovf_q;

endmodule
